// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised maximal-length LFSR with runtime Galois/Fibonacci
// selection, seed load, multi-step advance, all-zero lock-up recovery and a
// wrap pulse when the sequence returns to the active seed.
module lfsr_gen #(
  parameter int             W      = 7,
  parameter logic [W-1:0]   G_TAPS = 7'b0111000,
  parameter logic [W-1:0]   F_TAPS = 7'b0000011,
  parameter logic [W-1:0]   SEED   = 7'b0000001,
  parameter int             STEPS  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         mode,
  output logic [W-1:0] out,
  output logic         wrap,
  output logic         lockup
);

  typedef enum logic {
    MODE_GALOIS    = 1'b0,
    MODE_FIBONACCI = 1'b1
  } mode_e;

  // Seed the sequence is currently measured against for the wrap pulse.
  logic [W-1:0] seed;
  // State after STEPS chained single steps from the current state.
  logic [W-1:0] adv;
  // Value a load actually installs: zero would lock the register up.
  logic [W-1:0] load_eff;

  // One right-shift LFSR step in the selected topology.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s,
                                             input mode_e m);
    logic [W-1:0] n;
    n = s >> 1;
    if (m == MODE_FIBONACCI) begin
      n[W-1] = ^(s & F_TAPS);
    end else begin
      for (int i = 0; i < W - 1; i++) begin
        n[i] = s[i+1] ^ (G_TAPS[i] & s[0]);
      end
      n[W-1] = s[0];
    end
    return n;
  endfunction

  // Unrolled STEPS-deep advance chain, evaluated every cycle.
  always_comb begin
    // NOTE: give every always_comb output a value before any conditional or
    // loop; a path that leaves it unassigned infers a latch.
    adv = out;
    for (int k = 0; k < STEPS; k++) begin
      adv = lfsr_step(adv, mode_e'(mode));
    end
  end

  // Substitute the reset seed for an all-zero load value.
  always_comb begin
    load_eff = (load_val == '0) ? SEED : load_val;
  end

  // State, active seed and the two single-cycle pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge values; blocking here would create order races.
    if (reset) begin
      out    <= SEED;
      seed   <= SEED;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (load) begin
      out    <= load_eff;
      seed   <= load_eff;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (en) begin
      if (out == '0) begin
        out    <= SEED;
        wrap   <= 1'b0;
        lockup <= 1'b1;
      end else begin
        out    <= adv;
        wrap   <= (adv == seed);
        lockup <= 1'b0;
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen with hand-computed sequences, on
// a STEPS=1 instance and a STEPS=3 instance sharing one stimulus bus.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [6:0] load_val;
  logic       mode;
  logic [6:0] out;
  logic       wrap;
  logic       lockup;
  logic [6:0] out3;
  logic       wrap3;
  logic       lockup3;

  int tests_run = 0;
  int tests_failed = 0;

  lfsr_gen dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .out(out), .wrap(wrap), .lockup(lockup)
  );

  lfsr_gen #(.STEPS(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .out(out3), .wrap(wrap3), .lockup(lockup3)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    load_val = 7'h00; mode = 1'b0;
    do_reset();
    tests_run++;
    if (out !== 7'h01 || wrap !== 1'b0 || lockup !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: out=%h wrap=%b lockup=%b, expected out=01 wrap=0 lockup=0",
               out, wrap, lockup);
    end
  endtask

  task automatic test_galois();
    logic [6:0] exp_seq [5] = '{7'h78, 7'h3C, 7'h1E, 7'h0F, 7'h7F};
    do_reset();
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests_run++;
      if (out !== exp_seq[i] || wrap !== 1'b0) begin
        tests_failed++;
        $display("FAIL galois[%0d]: out=%h wrap=%b, expected out=%h wrap=0",
                 i, out, wrap, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_fibonacci();
    logic [6:0] exp_seq [7] = '{7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h41};
    do_reset();
    mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      tests_run++;
      if (out !== exp_seq[i] || wrap !== 1'b0) begin
        tests_failed++;
        $display("FAIL fibonacci[%0d]: out=%h wrap=%b, expected out=%h wrap=0",
                 i, out, wrap, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_hold();
    logic [6:0] held;
    held = out;
    en = 1'b0; load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests_run++;
      if (out !== held || wrap !== 1'b0 || lockup !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold[%0d]: out=%h wrap=%b lockup=%b, expected out=%h wrap=0 lockup=0",
                 i, out, wrap, lockup, held);
      end
    end
  endtask

  // Full period from a loaded seed; wrap must point at the loaded value.
  task automatic test_load();
    do_reset();
    mode = 1'b1; en = 1'b1; load = 1'b1; load_val = 7'h55;
    cycle();
    load = 1'b0;
    tests_run++;
    if (out !== 7'h55 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_55: out=%h wrap=%b, expected out=55 wrap=0", out, wrap);
    end
    for (int i = 1; i <= 127; i++) begin
      cycle();
      if (i == 127) begin
        tests_run++;
        if (out !== 7'h55 || wrap !== 1'b1) begin
          tests_failed++;
          $display("FAIL load_wrap: out=%h wrap=%b, expected out=55 wrap=1", out, wrap);
        end
      end else if (out === 7'h55 || wrap !== 1'b0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL load_early[%0d]: out=%h wrap=%b, expected out!=55 wrap=0",
                 i, out, wrap);
      end
    end
    en = 1'b0;
  endtask

  // Reset must revert the active seed to 0x01 after the earlier 0x55 load.
  task automatic test_period();
    bit seen [128];
    int repeats = 0;
    int early_wraps = 0;
    do_reset();
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    seen[out] = 1'b1;
    mode = 1'b1; en = 1'b1;
    for (int i = 1; i <= 127; i++) begin
      cycle();
      if (i < 127) begin
        if (seen[out]) repeats++;
        if (wrap !== 1'b0) early_wraps++;
        seen[out] = 1'b1;
      end
    end
    tests_run++;
    if (out !== 7'h01 || wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL period_wrap: out=%h wrap=%b, expected out=01 wrap=1", out, wrap);
    end
    tests_run++;
    if (repeats != 0 || early_wraps != 0) begin
      tests_failed++;
      $display("FAIL period_unique: repeats=%0d early_wraps=%0d, expected 0 and 0",
               repeats, early_wraps);
    end
    cycle();
    tests_run++;
    if (out !== 7'h40 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL period_after: out=%h wrap=%b, expected out=40 wrap=0", out, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_lockup();
    do_reset();
    mode = 1'b1; en = 1'b0;
    load = 1'b1; load_val = 7'h00;
    cycle();
    load = 1'b0;
    tests_run++;
    if (out !== 7'h01) begin
      tests_failed++;
      $display("FAIL load_zero: out=%h, expected out=01", out);
    end
    force dut.out = 7'h00;
    #1;
    release dut.out;
    #1;
    tests_run++;
    if (out !== 7'h00) begin
      tests_failed++;
      $display("FAIL force_zero: out=%h, expected out=00", out);
    end
    en = 1'b1;
    cycle();
    tests_run++;
    if (out !== 7'h01 || lockup !== 1'b1 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL lockup: out=%h lockup=%b wrap=%b, expected out=01 lockup=1 wrap=0",
               out, lockup, wrap);
    end
    cycle();
    tests_run++;
    if (out !== 7'h40 || lockup !== 1'b0) begin
      tests_failed++;
      $display("FAIL lockup_clear: out=%h lockup=%b, expected out=40 lockup=0",
               out, lockup);
    end
    en = 1'b0;
  endtask

  // G: 01->78, F: 78->3C, G: 3C->1E, F: 1E->4F (Galois would give 0F).
  task automatic test_mode_switch();
    logic       modes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [6:0] exp_seq [4] = '{7'h78, 7'h3C, 7'h1E, 7'h4F};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode = modes[i];
      cycle();
      tests_run++;
      if (out !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL mode_switch[%0d]: out=%h, expected out=%h", i, out, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  // STEPS=3 Galois: 01 -> 1E, hold, 1E -> 0F -> 7F -> 47, then reset.
  task automatic test_steps3();
    do_reset();
    tests_run++;
    if (out3 !== 7'h01) begin
      tests_failed++;
      $display("FAIL steps3_reset: out=%h, expected out=01", out3);
    end
    mode = 1'b0; en = 1'b1;
    cycle();
    tests_run++;
    if (out3 !== 7'h1E || wrap3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL steps3_adv1: out=%h wrap=%b, expected out=1E wrap=0", out3, wrap3);
    end
    en = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if (out3 !== 7'h1E) begin
      tests_failed++;
      $display("FAIL steps3_hold: out=%h, expected out=1E", out3);
    end
    en = 1'b1;
    cycle();
    tests_run++;
    if (out3 !== 7'h47) begin
      tests_failed++;
      $display("FAIL steps3_adv2: out=%h, expected out=47", out3);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0; en = 1'b0;
    tests_run++;
    if (out3 !== 7'h01 || wrap3 !== 1'b0 || lockup3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL steps3_midreset: out=%h wrap=%b lockup=%b, expected out=01 wrap=0 lockup=0",
               out3, wrap3, lockup3);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 7'h00; mode = 1'b0;
    #2;
    test_reset();
    test_galois();
    test_hold();
    test_fibonacci();
    test_load();
    test_period();
    test_lockup();
    test_mode_switch();
    test_steps3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
